alu_iter: RTL and testbench

ALU_ITER -- requirements
Module: alu_iter

---
 rtl/alu_iter.sv | 169 ++++++++++++++++
 tb/tb_alu_iter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle add/sub/and/or/slt, multi-cycle unsigned
// shift-add multiply and restoring divide sharing one hi/lo shift register.
//
//   state | meaning
//   IDLE  | waiting for START
//   RUN   | one mul/div step per cycle, counter counting down to 1
//   FIN   | DONE pulse; START accepted here as in IDLE
module alu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [2:0]       ALUOP,
    input  logic [5:0]       FUNCTION,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic             BUSY,
    output logic             DONE,
    output logic             ZERO,
    output logic             DIV_BY_ZERO
);

    typedef enum logic [2:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_DIV
    } op_t;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state;
    op_t              dec_op;
    logic [CNT_W-1:0] cnt;
    logic             is_mul;
    logic [WIDTH-1:0] hi, lo, opnd;

    logic [WIDTH-1:0] quick_res;
    logic             slt_bit;
    logic             multi;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH:0]   div_sh, div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] div_hi, div_lo;
    logic [WIDTH-1:0] step_hi, step_lo;

    always_comb begin
        dec_op = OP_NOP;
        if (ALUOP == 3'b010) begin
            case (FUNCTION)
                6'b100000: dec_op = OP_ADD;
                6'b100010: dec_op = OP_SUB;
                6'b100100: dec_op = OP_AND;
                6'b100101: dec_op = OP_OR;
                6'b101010: dec_op = OP_SLT;
                6'b011000: dec_op = OP_MUL;
                6'b011010: dec_op = OP_DIV;
                default:   dec_op = OP_NOP;
            endcase
        end else begin
            case (ALUOP)
                3'b011:  dec_op = OP_ADD;
                3'b100:  dec_op = OP_SUB;
                3'b111:  dec_op = OP_AND;
                3'b101:  dec_op = OP_OR;
                3'b001:  dec_op = OP_SLT;
                default: dec_op = OP_NOP;
            endcase
        end
    end

    assign slt_bit = ($signed(A) < $signed(B));
    assign multi   = (dec_op == OP_MUL) || ((dec_op == OP_DIV) && (B != '0));

    always_comb begin
        quick_res = '0;
        case (dec_op)
            OP_ADD:  quick_res = A + B;
            OP_SUB:  quick_res = A - B;
            OP_AND:  quick_res = A & B;
            OP_OR:   quick_res = A | B;
            OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_DIV:  quick_res = '1;
            default: quick_res = '0;
        endcase
    end

    // Multiply: hi accumulates, lo holds the multiplier and collects product low bits.
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lo[WIDTH-1:1]};

    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    assign div_sh   = {hi, lo[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opnd};
    assign div_ok   = ~div_diff[WIDTH];
    assign div_hi   = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_lo   = {lo[WIDTH-2:0], div_ok};

    assign step_hi = is_mul ? mul_hi : div_hi;
    assign step_lo = is_mul ? mul_lo : div_lo;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            RESULT      <= '0;
            RESULT_HI   <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            ZERO        <= 1'b0;
            DIV_BY_ZERO <= 1'b0;
            cnt         <= '0;
            is_mul      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            opnd        <= '0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    state <= IDLE;
                    DONE  <= 1'b0;
                    if (START) begin
                        if (multi) begin
                            state  <= RUN;
                            BUSY   <= 1'b1;
                            cnt    <= CNT_W'(WIDTH);
                            is_mul <= (dec_op == OP_MUL);
                            hi     <= '0;
                            lo     <= (dec_op == OP_MUL) ? B : A;
                            opnd   <= (dec_op == OP_MUL) ? A : B;
                        end else begin
                            state       <= FIN;
                            DONE        <= 1'b1;
                            DIV_BY_ZERO <= (dec_op == OP_DIV);
                            if (dec_op != OP_NOP) begin
                                RESULT    <= quick_res;
                                RESULT_HI <= (dec_op == OP_DIV) ? A : '0;
                                ZERO      <= (quick_res == '0);
                            end
                        end
                    end
                end
                RUN: begin
                    hi  <= step_hi;
                    lo  <= step_lo;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state       <= FIN;
                        BUSY        <= 1'b0;
                        DONE        <= 1'b1;
                        RESULT      <= step_lo;
                        RESULT_HI   <= step_hi;
                        ZERO        <= (step_lo == '0);
                        DIV_BY_ZERO <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter at WIDTH=8: expected results are queued when
// an operation is driven and popped when DONE is observed.
module tb_alu_iter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [2:0]   aluop;
    logic [5:0]   fn;
    logic [W-1:0] a, b, result, result_hi;
    logic         busy, done, zero, dbz;

    always #5 clk = ~clk;

    alu_iter #(.WIDTH(W)) dut (
        .CLK(clk), .RST(rst), .START(start), .ALUOP(aluop), .FUNCTION(fn),
        .A(a), .B(b), .RESULT(result), .RESULT_HI(result_hi),
        .BUSY(busy), .DONE(done), .ZERO(zero), .DIV_BY_ZERO(dbz)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    exp_t m_prev;
    exp_t e;
    int   checks = 0;
    int   passed = 0;
    int   n;

    function automatic int kind(input logic [2:0] op, input logic [5:0] f);
        if (op == 3'b010) begin
            case (f)
                6'b100000: return 1;
                6'b100010: return 2;
                6'b100100: return 3;
                6'b100101: return 4;
                6'b101010: return 5;
                6'b011000: return 6;
                6'b011010: return 7;
                default:   return 0;
            endcase
        end
        case (op)
            3'b011:  return 1;
            3'b100:  return 2;
            3'b111:  return 3;
            3'b101:  return 4;
            3'b001:  return 5;
            default: return 0;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [5:0] f,
                         input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t x;
        logic [2*W-1:0] p;
        int k;
        aluop = op; fn = f; a = av; b = bv; start = 1'b1;
        k = kind(op, f);
        x = '0;
        case (k)
            1: x.res = av + bv;
            2: x.res = av - bv;
            3: x.res = av & bv;
            4: x.res = av | bv;
            5: x.res = ($signed(av) < $signed(bv)) ? 8'd1 : 8'd0;
            6: begin
                p = {8'd0, av} * {8'd0, bv};
                x.res = p[W-1:0];
                x.hi  = p[2*W-1:W];
            end
            7: begin
                if (bv == 0) begin
                    x.res = 8'hFF; x.hi = av; x.dbz = 1'b1;
                end else begin
                    x.res = av / bv; x.hi = av % bv;
                end
            end
            default: begin
                x.res = m_prev.res; x.hi = m_prev.hi;
            end
        endcase
        x.zero = (k == 0) ? m_prev.zero : (x.res == 0);
        sb.push_back(x);
        m_prev = x;
    endtask

    // Consumes the accepting edge, drops START, then waits for DONE.
    task automatic wait_done(output int cyc);
        tick;
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            tick;
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; aluop = 3'b011; fn = 6'd0; a = 8'd3; b = 8'd4;
        tick; tick;
        checks++; if (result !== 8'h00)    $display("FAIL reset_result got %h want 00", result);    else passed++;
        checks++; if (result_hi !== 8'h00) $display("FAIL reset_hi got %h want 00", result_hi);     else passed++;
        checks++; if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done got %b want 00", {busy, done}); else passed++;
        checks++; if ({zero, dbz} !== 2'b00)  $display("FAIL reset_flags got %b want 00", {zero, dbz}); else passed++;
        rst = 1'b0; start = 1'b0;
        tick;
        checks++; if (done !== 1'b0) $display("FAIL reset_start_discarded done=%b want 0", done); else passed++;
        m_prev = '0;
    endtask

    task automatic test_mul;
        drive(3'b010, 6'b011000, 8'd200, 8'd3);
        tick;
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if ({busy, done} !== 2'b10) $display("FAIL mul_busy cycle %0d busy,done=%b want 10", c, {busy, done});
            else passed++;
            tick;
        end
        checks++; if ({busy, done} !== 2'b01) $display("FAIL mul_done busy,done=%b want 01", {busy, done}); else passed++;
        checks++; if ({result_hi, result} !== 16'h0258) $display("FAIL mul_const got %h%h want 0258", result_hi, result); else passed++;
        checks++;
        if (sb.size() == 0) $display("FAIL mul_sb empty queue");
        else begin
            e = sb.pop_front();
            if ({result, result_hi, zero, dbz} !== {e.res, e.hi, e.zero, e.dbz})
                $display("FAIL mul_result got %h/%h z%b d%b want %h/%h z%b d%b", result, result_hi, zero, dbz, e.res, e.hi, e.zero, e.dbz);
            else passed++;
        end
        tick;
        checks++; if (done !== 1'b0) $display("FAIL mul_done_pulse done=%b want 0", done); else passed++;
    endtask

    task automatic test_div;
        drive(3'b010, 6'b011010, 8'd100, 8'd7);
        wait_done(n);
        checks++; if (n !== 9) $display("FAIL div_latency got %0d want 9", n); else passed++;
        checks++;
        if (sb.size() == 0) $display("FAIL div_sb empty queue");
        else begin
            e = sb.pop_front();
            if ({result, result_hi, zero, dbz} !== {e.res, e.hi, e.zero, e.dbz})
                $display("FAIL div_result got %h/%h z%b d%b want %h/%h z%b d%b", result, result_hi, zero, dbz, e.res, e.hi, e.zero, e.dbz);
            else passed++;
        end
        drive(3'b010, 6'b011010, 8'd5, 8'd0);
        wait_done(n);
        checks++; if (n !== 1) $display("FAIL div0_latency got %0d want 1", n); else passed++;
        checks++;
        if (sb.size() == 0) $display("FAIL div0_sb empty queue");
        else begin
            e = sb.pop_front();
            if ({result, result_hi, zero, dbz} !== {e.res, e.hi, e.zero, e.dbz})
                $display("FAIL div0_result got %h/%h z%b d%b want %h/%h z%b d%b", result, result_hi, zero, dbz, e.res, e.hi, e.zero, e.dbz);
            else passed++;
        end
        tick;
    endtask

    task automatic test_back_to_back;
        drive(3'b001, 6'd0, 8'hFD, 8'd5);
        tick;
        checks++; if (done !== 1'b1) $display("FAIL b2b_done1 done=%b want 1", done); else passed++;
        checks++;
        if (sb.size() == 0) $display("FAIL b2b_slt_sb empty queue");
        else begin
            e = sb.pop_front();
            if ({result, result_hi, zero, dbz} !== {e.res, e.hi, e.zero, e.dbz})
                $display("FAIL b2b_slt got %h/%h z%b d%b want %h/%h z%b d%b", result, result_hi, zero, dbz, e.res, e.hi, e.zero, e.dbz);
            else passed++;
        end
        drive(3'b100, 6'd0, 8'd9, 8'd9);
        tick;
        checks++; if (done !== 1'b1) $display("FAIL b2b_done2 done=%b want 1", done); else passed++;
        checks++;
        if (sb.size() == 0) $display("FAIL b2b_sub_sb empty queue");
        else begin
            e = sb.pop_front();
            if ({result, result_hi, zero, dbz} !== {e.res, e.hi, e.zero, e.dbz})
                $display("FAIL b2b_sub got %h/%h z%b d%b want %h/%h z%b d%b", result, result_hi, zero, dbz, e.res, e.hi, e.zero, e.dbz);
            else passed++;
        end
        start = 1'b0;
        tick;
        checks++; if (done !== 1'b0) $display("FAIL b2b_idle done=%b want 0", done); else passed++;
    endtask

    task automatic test_busy_ignore;
        int extra;
        drive(3'b010, 6'b011000, 8'hB7, 8'h5C);
        tick;
        start = 1'b0;
        tick; tick; tick;
        aluop = 3'b011; fn = 6'd0; a = 8'd1; b = 8'd1; start = 1'b1;
        tick;
        start = 1'b0;
        n = 5;
        while (done !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        checks++; if (n !== 9) $display("FAIL ignore_latency got %0d want 9", n); else passed++;
        checks++;
        if (sb.size() == 0) $display("FAIL ignore_sb empty queue");
        else begin
            e = sb.pop_front();
            if ({result, result_hi, zero, dbz} !== {e.res, e.hi, e.zero, e.dbz})
                $display("FAIL ignore_result got %h/%h z%b d%b want %h/%h z%b d%b", result, result_hi, zero, dbz, e.res, e.hi, e.zero, e.dbz);
            else passed++;
        end
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (done === 1'b1) extra++;
        end
        checks++; if (extra !== 0) $display("FAIL ignore_extra_done got %0d want 0", extra); else passed++;
    endtask

    task automatic test_reset_abort;
        int extra;
        drive(3'b010, 6'b011000, 8'd200, 8'd3);
        tick;
        start = 1'b0;
        tick; tick; tick; tick;
        rst = 1'b1;
        tick;
        checks++;
        if ({result, result_hi, busy, done, zero, dbz} !== '0)
            $display("FAIL abort_outputs got %h/%h b%b d%b z%b dz%b want all 0", result, result_hi, busy, done, zero, dbz);
        else passed++;
        rst = 1'b0;
        sb.delete();
        m_prev = '0;
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++; if (extra !== 0) $display("FAIL abort_no_done got %0d activity cycles want 0", extra); else passed++;
    endtask

    task automatic test_nop;
        drive(3'b010, 6'b011000, 8'd200, 8'd3);
        wait_done(n);
        if (sb.size() != 0) e = sb.pop_front();
        tick;
        drive(3'b000, 6'b100000, 8'h11, 8'h22);
        wait_done(n);
        checks++; if (n !== 1) $display("FAIL nop1_latency got %0d want 1", n); else passed++;
        checks++; if (result !== 8'h58) $display("FAIL nop1_hold got %h want 58", result); else passed++;
        checks++;
        if (sb.size() == 0) $display("FAIL nop1_sb empty queue");
        else begin
            e = sb.pop_front();
            if ({result, result_hi, zero, dbz} !== {e.res, e.hi, e.zero, e.dbz})
                $display("FAIL nop1_result got %h/%h z%b d%b want %h/%h z%b d%b", result, result_hi, zero, dbz, e.res, e.hi, e.zero, e.dbz);
            else passed++;
        end
        drive(3'b010, 6'b000000, 8'h33, 8'h44);
        wait_done(n);
        checks++;
        if (sb.size() == 0) $display("FAIL nop2_sb empty queue");
        else begin
            e = sb.pop_front();
            if (n !== 1 || {result, result_hi, zero, dbz} !== {e.res, e.hi, e.zero, e.dbz})
                $display("FAIL nop2_result lat %0d got %h/%h z%b d%b want lat 1 %h/%h z%b d%b", n, result, result_hi, zero, dbz, e.res, e.hi, e.zero, e.dbz);
            else passed++;
        end
        drive(3'b010, 6'b011010, 8'h42, 8'd0);
        wait_done(n);
        if (sb.size() != 0) e = sb.pop_front();
        checks++; if (dbz !== 1'b1) $display("FAIL div0_flag got %b want 1", dbz); else passed++;
        drive(3'b110, 6'd0, 8'h00, 8'h00);
        wait_done(n);
        checks++;
        if (sb.size() == 0) $display("FAIL nop3_sb empty queue");
        else begin
            e = sb.pop_front();
            if ({result, result_hi, zero, dbz} !== {e.res, e.hi, e.zero, e.dbz})
                $display("FAIL nop3_clear_dbz got %h/%h z%b d%b want %h/%h z%b d%b", result, result_hi, zero, dbz, e.res, e.hi, e.zero, e.dbz);
            else passed++;
        end
        tick;
    endtask

    task automatic test_random;
        logic [2:0] op;
        logic [5:0] f;
        logic [W-1:0] av, bv;
        int k, lat;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 11))
                0:  begin op = 3'b010; f = 6'b100000; end
                1:  begin op = 3'b010; f = 6'b100010; end
                2:  begin op = 3'b010; f = 6'b100100; end
                3:  begin op = 3'b010; f = 6'b100101; end
                4:  begin op = 3'b010; f = 6'b101010; end
                5:  begin op = 3'b010; f = 6'b011000; end
                6:  begin op = 3'b010; f = 6'b011010; end
                7:  begin op = 3'b011; f = 6'b000000; end
                8:  begin op = 3'b100; f = 6'b000000; end
                9:  begin op = 3'b111; f = 6'b000000; end
                10: begin op = 3'b101; f = 6'b000000; end
                default: begin op = 3'b001; f = 6'b000000; end
            endcase
            av = W'($urandom);
            bv = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom);
            k = kind(op, f);
            lat = (k == 6 || (k == 7 && bv != 0)) ? 9 : 1;
            drive(op, f, av, bv);
            wait_done(n);
            checks++;
            if (sb.size() == 0) $display("FAIL rand%0d_sb empty queue", i);
            else begin
                e = sb.pop_front();
                if (n !== lat || {result, result_hi, zero, dbz} !== {e.res, e.hi, e.zero, e.dbz})
                    $display("FAIL rand%0d op=%b f=%b a=%h b=%h lat %0d got %h/%h z%b d%b want lat %0d %h/%h z%b d%b",
                             i, op, f, av, bv, n, result, result_hi, zero, dbz, lat, e.res, e.hi, e.zero, e.dbz);
                else passed++;
            end
        end
        tick;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; aluop = 3'b000; fn = 6'd0; a = '0; b = '0;
        m_prev = '0;
        test_reset;
        test_mul;
        test_div;
        test_back_to_back;
        test_busy_ignore;
        test_reset_abort;
        test_nop;
        test_random;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
